uart_tx_controller: RTL and testbench
=====================================

Name: uart_tx_controller

Overview:
Memory-mapped UART transmitter. It is the transmit-side counterpart of the CPU's UART receive controller and sits on the same GPIO peripheral bus. The CPU writes bytes into a small TX FIFO. A baud-timed serializer drains the FIFO onto uart_tx as 8N1 frames, LSB first. Status and fill level are readable so firmware can poll instead of blocking.

Parameters:
CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); legal range 4..65535.
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
wen  input  1  bus write strobe, single-cycle.
ren  input  1  bus read strobe, single-cycle.
address  input  2  register select.
data_in  input  32  write data; only [7:0] used.
data_out  output  32  registered read data.
uart_tx  output  1  serial line, idle high.
tx_busy  output  1  high while FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - uart_tx=1, data_out=0, tx_busy=0.
  - FIFO pointers and count cleared; FSM forced to IDLE; overflow flag cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high.
- Register map:
  - 0 DATA: write pushes data_in[7:0]; read returns 0.
  - 1 STATUS, read-only: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow (sticky); other bits 0.
  - 2 LEVEL: read returns the FIFO count, zero-extended.
  - 3: reserved; reads 0, writes ignored.
- Read timing:
  - data_out updates on the clock edge where ren=1, so data is valid in the next cycle.
  - data_out holds its value when ren=0.
  - A read of STATUS clears overflow in the same edge; the returned value still shows overflow=1.
- Writes:
  - A write to DATA when the registered full flag is 1 is dropped and sets overflow. This applies even if a pop occurs in the same cycle.
  - If wen and ren are both high, both take effect.
- FIFO:
  - Push and pop may occur in the same cycle; count is unchanged in that case.
  - Pointers wrap modulo FIFO_DEPTH.
  - count width is clog2(FIFO_DEPTH)+1, so count==FIFO_DEPTH is representable.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO is non-empty, pop, load the shift register, clear baud_cnt and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right each bit. After bit_idx=7 completes, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO is non-empty, pop and go directly to START (zero idle gap). Otherwise go to IDLE.
- Latency: a write to DATA at edge N with an empty FIFO and idle FSM → pop at edge N+1 → uart_tx falls after edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- tx_busy is combinational: (count!=0) || (state!=IDLE).

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, so a frame is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; plain 8N1.

Decomposition:
- Package uart_pkg holds:
  - state encoding enum (IDLE, START, DATA, PARITY, STOP);
  - register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_LEVEL=2);
  - STATUS bit-index constants.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, din[7:0], dout, full, empty, count, and the same clk/reset.
- Top level holds the bus decode, overflow flag and serializer FSM.

Test Plan:
- Reset check: assert reset mid-frame → uart_tx=1, tx_busy=0, LEVEL read returns 0 within the same cycle of assertion.
- Single byte: CLKS_PER_BIT=4, write 0xA5 → uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; falls 2 cycles after the write; tx_busy drops after 40 cycles.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles → two frames with no idle cycle between the first stop bit and the second start bit.
- Overflow: FIFO_DEPTH=8, fill 9 bytes while the first frame is held in START → first STATUS read returns 0x0D (full|busy|overflow); second read shows overflow=0; the dropped byte is never transmitted.
- Level/readback: write 3 bytes while idle, read LEVEL the next cycle → returns 2 (one already popped).
- Parity (UART_TX_PARITY_EN defined): write 0x07 → 11-bit frame with parity bit 1; write 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the UART transmit controller.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_LEVEL  = 2'd2;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Byte-wide synchronous FIFO; full/empty derive from the registered count.
// Rev    : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_controller
// Brief  : Memory-mapped 8N1 UART transmitter with TX FIFO and status regs.
//          Define UART_TX_PARITY_EN to add an even-parity bit before STOP.
// Rev    : 1.0
// ============================================================================
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_baud_last = 16'(CLKS_PER_BIT - 1);

    tx_state_t   r_state, w_state_nx;
    logic [15:0] r_baud, w_baud_nx;
    logic [2:0]  r_bit_idx, w_bit_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_tx, w_tx_nx;
    logic        r_ovf;
    logic [31:0] r_data_out;
    logic [31:0] w_status;
    logic        w_push, w_pop, w_full, w_empty, w_baud_last;
    logic [7:0]  w_dout;
    logic [CW-1:0] w_count;
    logic        w_unused;

    assign w_unused    = ^data_in[31:8];
    assign w_push      = wen && (address == ADDR_DATA);
    assign w_baud_last = (r_baud == c_baud_last);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

`ifdef UART_TX_PARITY_EN
    logic r_parity, w_parity_nx;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud + 16'd1;
        w_bit_nx   = r_bit_idx;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        w_tx_nx    = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_nx = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_baud_nx = '0;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_dout;
`ifdef UART_TX_PARITY_EN
                    w_parity_nx = ^w_dout;
`endif
                    w_state_nx = START;
                end
            end
            START: begin
                w_tx_nx = 1'b0;
                if (w_baud_last) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = 3'd0;
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                w_tx_nx = r_shift[0];
                if (w_baud_last) begin
                    w_baud_nx  = '0;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_bit_nx   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_nx = r_parity;
                if (w_baud_last) begin
                    w_baud_nx  = '0;
                    w_state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (w_baud_last) begin
                    w_baud_nx = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_dout;
`ifdef UART_TX_PARITY_EN
                        w_parity_nx = ^w_dout;
`endif
                        w_state_nx = START;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // The line is registered, so it lags the state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_baud    <= w_baud_nx;
            r_bit_idx <= w_bit_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nx;
`endif
        end
    end

    always_comb begin
        w_status            = '0;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BUSY]  = tx_busy;
        w_status[STAT_OVF]   = r_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push && w_full)
                r_ovf <= 1'b1;
            else if (ren && (address == ADDR_STATUS))
                r_ovf <= 1'b0;
            if (ren) begin
                case (address)
                    ADDR_STATUS: r_data_out <= w_status;
                    ADDR_LEVEL:  r_data_out <= 32'(w_count);
                    default:     r_data_out <= '0;
                endcase
            end
        end
    end

    assign data_out = r_data_out;
    assign uart_tx  = r_tx;
    assign tx_busy  = (w_count != '0) || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_controller
// Brief  : Directed self-checking bench for uart_tx_controller.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_controller;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        uart_tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wen      (wen),
        .ren      (ren),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit slot i of a frame carrying d.
    function automatic logic fbit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called right after the edge on which the start bit first appears.
    task automatic check_frame(input logic [7:0] d, input bit last);
        for (int c = 0; c < FRAME; c++) begin
            chk($sformatf("tx_%02h_c%0d", d, c), {31'd0, uart_tx}, {31'd0, fbit(d, c / CPB)});
            chk($sformatf("busy_%02h_c%0d", d, c), {31'd0, tx_busy},
                {31'd0, !(last && c == FRAME - 1)});
            tick();
        end
    endtask

    task automatic send_single(input logic [7:0] d);
        wen = 1'b1; address = 2'd0; data_in = {24'd0, d};
        tick();
        wen = 1'b0;
        chk("lat_tx_n0", {31'd0, uart_tx}, 32'd1);
        chk("lat_busy_n0", {31'd0, tx_busy}, 32'd1);
        tick();
        chk("lat_tx_n1", {31'd0, uart_tx}, 32'd1);
        tick();
        check_frame(d, 1'b1);
        chk("post_tx", {31'd0, uart_tx}, 32'd1);
        chk("post_busy", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        reset = 1'b0;
        tick();

        send_single(8'hA5);
        send_single(8'h07);
        send_single(8'h03);

        // back-to-back frames with no idle gap
        wen = 1'b1; address = 2'd0; data_in = 32'h00;
        tick();
        data_in = 32'hFF;
        tick();
        wen = 1'b0;
        tick();
        check_frame(8'h00, 1'b0);
        check_frame(8'hFF, 1'b1);

        // level readback: one of three bytes is already popped
        wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'h30 + 32'(i);
            tick();
        end
        wen = 1'b0; ren = 1'b1; address = 2'd2;
        tick();
        ren = 1'b0;
        chk("level3", data_out, 32'd2);
        tick();
        chk("level_hold", data_out, 32'd2);
        ren = 1'b1; address = 2'd3;
        tick();
        ren = 1'b0;
        chk("reserved_rd", data_out, 32'd0);
        for (int i = 0; i < 2000 && tx_busy; i++) tick();
        chk("drain_busy", {31'd0, tx_busy}, 32'd0);
        ren = 1'b1; address = 2'd1;
        tick();
        ren = 1'b0;
        chk("status_idle", data_out, 32'h02);

        // overflow: 10 writes, the 10th is dropped
        wen = 1'b1; address = 2'd0;
        for (int i = 0; i < 10; i++) begin
            data_in = 32'h10 + 32'(i);
            tick();
        end
        wen = 1'b0; ren = 1'b1; address = 2'd1;
        tick();
        chk("status_ovf", data_out, 32'h0D);
        tick();
        chk("status_ovf_clr", data_out, 32'h05);
        address = 2'd2;
        tick();
        ren = 1'b0;
        chk("level_full", data_out, 32'd8);
        repeat (FRAME - 10) tick();
        for (int i = 1; i <= 8; i++) check_frame(8'(8'h10 + i), i == 8);
        repeat (CPB * 2) tick();
        chk("ovf_no_extra_tx", {31'd0, uart_tx}, 32'd1);
        chk("ovf_no_extra_busy", {31'd0, tx_busy}, 32'd0);

        // asynchronous reset in the middle of a frame
        wen = 1'b1; address = 2'd0; data_in = 32'h55;
        tick();
        data_in = 32'h66;
        tick();
        wen = 1'b0; ren = 1'b1; address = 2'd2;
        tick();
        ren = 1'b0;
        chk("pre_rst_level", data_out, 32'd1);
        repeat (6) tick();
        chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_tx", {31'd0, uart_tx}, 32'd1);
        chk("arst_busy", {31'd0, tx_busy}, 32'd0);
        chk("arst_dout", data_out, 32'd0);
        tick();
        reset = 1'b0;
        ren = 1'b1; address = 2'd2;
        tick();
        chk("post_rst_level", data_out, 32'd0);
        address = 2'd1;
        tick();
        ren = 1'b0;
        chk("post_rst_status", data_out, 32'h02);
        repeat (FRAME) tick();
        chk("post_rst_line", {31'd0, uart_tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
